// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel strobe, h/v counters, registered syncs
// and the per-frame refresh tick used by the object renderers.
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic       refr_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;

  assign p_tick = (div_q == DIV_LAST);

  // Syncs are derived from the next-state counters so they flip on the same
  // edge as the coordinates they belong to.
  always_comb begin
    div_d = p_tick ? '0 : div_q + DIV_W'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (p_tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    hsync_d = !((h_d >= HS_FIRST) && (h_d <= HS_LAST));
    vsync_d = !((v_d >= VS_FIRST) && (v_d <= VS_LAST));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign pix_x     = h_q;
  assign pix_y     = v_q;
  assign video_on  = (h_q < H_VIS) && (v_q < V_VIS);
  assign refr_tick = p_tick && (h_q == 10'd0) && (v_q == V_VIS);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing over one line plus two
// shrunken rasters (CLK_DIV=1 and CLK_DIV=2) that are short enough to sweep whole frames.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset0 = 1'b1, reset1 = 1'b1, reset2 = 1'b1;
  logic hs0, vs0, vo0, pt0, rt0;
  logic hs1, vs1, vo1, pt1, rt1;
  logic hs2, vs2, vo2, pt2, rt2;
  logic [9:0] x0, y0, x1, y1, x2, y2;

  int vectors = 0;
  int miscompares = 0;

  int model_errs, hs_low, vs_low, refr_cnt, refr_k, refr_x, refr_y, vid_ticks;
  int line_wrap_k, line_wrap_y, frame_wrap_k, hs_fall_x, hs_rise_x;

  vga_timing_gen u_dut0 (
    .clk(clk), .reset(reset0), .hsync(hs0), .vsync(vs0), .video_on(vo0),
    .p_tick(pt0), .refr_tick(rt0), .pix_x(x0), .pix_y(y0)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3)
  ) u_dut1 (
    .clk(clk), .reset(reset1), .hsync(hs1), .vsync(vs1), .video_on(vo1),
    .p_tick(pt1), .refr_tick(rt1), .pix_x(x1), .pix_y(y1)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3)
  ) u_dut2 (
    .clk(clk), .reset(reset2), .hsync(hs2), .vsync(vs2), .video_on(vo2),
    .p_tick(pt2), .refr_tick(rt2), .pix_x(x2), .pix_y(y2)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic sample(input int d, output logic [9:0] x, output logic [9:0] y,
                        output logic hs, output logic vs, output logic vo,
                        output logic pt, output logic rt);
    case (d)
      0:       begin x = x0; y = y0; hs = hs0; vs = vs0; vo = vo0; pt = pt0; rt = rt0; end
      1:       begin x = x1; y = y1; hs = hs1; vs = vs1; vo = vo1; pt = pt1; rt = rt1; end
      default: begin x = x2; y = y2; hs = hs2; vs = vs2; vo = vo2; pt = pt2; rt = rt2; end
    endcase
  endtask

  // Edge k is the k-th rising edge after reset release; a reference raster
  // computed from k is compared against the DUT after every edge.
  task automatic applyStimulus(input int d, input int dv, input int k_first, input int k_last,
                               input int hdisp, input int hfront, input int hsw, input int hback,
                               input int vdisp, input int vfront, input int vsw, input int vback);
    int htot, vtot, t, ex, ey;
    logic eh, ev, evo, ept, ert;
    logic [9:0] x, y, px, py;
    logic hs, vs, vo, pt, rt, phs, pvs, pvo, ppt, prt;
    htot = hdisp + hfront + hsw + hback;
    vtot = vdisp + vfront + vsw + vback;
    model_errs = 0; hs_low = 0; vs_low = 0; refr_cnt = 0; vid_ticks = 0;
    refr_k = -1; refr_x = -1; refr_y = -1; line_wrap_k = -1; line_wrap_y = -1;
    frame_wrap_k = -1; hs_fall_x = -1; hs_rise_x = -1;
    sample(d, px, py, phs, pvs, pvo, ppt, prt);
    for (int k = k_first; k <= k_last; k++) begin
      @(negedge clk);
      sample(d, x, y, hs, vs, vo, pt, rt);
      t   = k / dv;
      ex  = t % htot;
      ey  = (t / htot) % vtot;
      ept = ((k % dv) == dv - 1);
      eh  = !((ex >= hdisp + hfront) && (ex <= hdisp + hfront + hsw - 1));
      ev  = !((ey >= vdisp + vfront) && (ey <= vdisp + vfront + vsw - 1));
      evo = (ex < hdisp) && (ey < vdisp);
      ert = ept && (ex == 0) && (ey == vdisp);
      if (int'(x) != ex || int'(y) != ey || hs !== eh || vs !== ev ||
          vo !== evo || pt !== ept || rt !== ert)
        model_errs++;
      if (hs === 1'b0) hs_low++;
      if (vs === 1'b0) vs_low++;
      if (vo === 1'b1 && pt === 1'b1) vid_ticks++;
      if (rt === 1'b1) begin
        refr_cnt++;
        if (refr_k < 0) begin refr_k = k; refr_x = int'(x); refr_y = int'(y); end
      end
      if (phs === 1'b1 && hs === 1'b0 && hs_fall_x < 0) hs_fall_x = int'(x);
      if (phs === 1'b0 && hs === 1'b1 && hs_rise_x < 0) hs_rise_x = int'(x);
      if (int'(px) == htot - 1 && x == 10'd0 && line_wrap_k < 0) begin
        line_wrap_k = k; line_wrap_y = int'(y);
      end
      if (int'(px) == htot - 1 && int'(py) == vtot - 1 && x == 10'd0 && y == 10'd0 &&
          frame_wrap_k < 0)
        frame_wrap_k = k;
      px = x; py = y; phs = hs;
    end
  endtask

  task automatic checkFirstPixels(input string pfx);
    @(negedge clk);
    checkOutput({pfx, "_e1_p_tick"}, int'(pt0), 1);
    checkOutput({pfx, "_e1_pix_x"}, int'(x0), 0);
    @(negedge clk);
    checkOutput({pfx, "_e2_pix_x"}, int'(x0), 1);
    checkOutput({pfx, "_e2_p_tick"}, int'(pt0), 0);
    checkOutput({pfx, "_e2_pix_y"}, int'(y0), 0);
  endtask

  initial begin
    int guard;
    $display("[TB] vga_timing_gen bench start");
    repeat (3) @(negedge clk);
    checkOutput("rst_pix_x", int'(x0), 0);
    checkOutput("rst_pix_y", int'(y0), 0);
    checkOutput("rst_hsync", int'(hs0), 1);
    checkOutput("rst_vsync", int'(vs0), 1);
    checkOutput("rst_video_on", int'(vo0), 1);
    checkOutput("rst_p_tick", int'(pt0), 0);
    checkOutput("rst_refr_tick", int'(rt0), 0);

    reset0 = 1'b0;
    checkFirstPixels("rel");
    applyStimulus(0, 2, 3, 1602, 640, 16, 96, 48, 480, 10, 2, 33);
    checkOutput("line_model_errs", model_errs, 0);
    checkOutput("hsync_fall_x", hs_fall_x, 656);
    checkOutput("hsync_rise_x", hs_rise_x, 752);
    checkOutput("hsync_low_clks", hs_low, 192);
    checkOutput("vsync_low_line0", vs_low, 0);
    checkOutput("line_wrap_edge", line_wrap_k, 1600);
    checkOutput("line_wrap_y", line_wrap_y, 1);

    guard = 0;
    while (x0 != 10'd300 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("reach_x300", int'(x0 == 10'd300), 1);
    checkOutput("hsync_at_x300", int'(hs0), 1);
    #2 reset0 = 1'b1;
    #1;
    checkOutput("mid_rst_pix_x", int'(x0), 0);
    checkOutput("mid_rst_pix_y", int'(y0), 0);
    checkOutput("mid_rst_hsync", int'(hs0), 1);
    checkOutput("mid_rst_vsync", int'(vs0), 1);
    checkOutput("mid_rst_p_tick", int'(pt0), 0);
    @(negedge clk);
    reset0 = 1'b0;
    checkFirstPixels("rerel");

    reset1 = 1'b0;
    applyStimulus(1, 1, 1, 180, 8, 2, 3, 2, 6, 1, 2, 3);
    checkOutput("div1_model_errs", model_errs, 0);
    checkOutput("div1_line_edge", line_wrap_k, 15);
    checkOutput("div1_line_y", line_wrap_y, 1);
    checkOutput("div1_frame_edge", frame_wrap_k, 180);
    checkOutput("div1_refr_count", refr_cnt, 1);
    checkOutput("div1_refr_edge", refr_k, 90);
    checkOutput("div1_vsync_low", vs_low, 30);
    checkOutput("div1_hsync_low", hs_low, 36);
    checkOutput("div1_video_ticks", vid_ticks, 48);

    reset2 = 1'b0;
    applyStimulus(2, 2, 1, 360, 8, 2, 3, 2, 6, 1, 2, 3);
    checkOutput("div2_model_errs", model_errs, 0);
    checkOutput("div2_frame_edge", frame_wrap_k, 360);
    checkOutput("div2_refr_count", refr_cnt, 1);
    checkOutput("div2_refr_edge", refr_k, 181);
    checkOutput("div2_refr_x", refr_x, 0);
    checkOutput("div2_refr_y", refr_y, 6);
    checkOutput("div2_vsync_low", vs_low, 60);
    checkOutput("div2_hsync_low", hs_low, 72);
    checkOutput("div2_video_ticks", vid_ticks, 48);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480 @ 60 Hz VGA raster timing that drives every pixel renderer in the display path. It produces hsync/vsync for the connector, the current pixel coordinate (pix_x, pix_y), the active-area flag video_on, a pixel-rate strobe p_tick, and a once-per-frame refr_tick used by sprite/logo blocks to update position registers. All object renderers and the RGB mux consume its outputs.

## Interface

- CLK_DIV, 2: clk cycles per pixel (50 MHz clk gives a 25 MHz pixel rate); legal values are ≥1.
- H_DISPLAY, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_DISPLAY, 480: visible lines per frame.
- V_FRONT, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BACK, 33: vertical back porch, in lines.

Ports:

- clk  input  1  system clock
- reset  input  1  asynchronous, active-high
- hsync  output  1  horizontal sync, active-low, registered
- vsync  output  1  vertical sync, active-low, registered
- video_on  output  1  high when (pix_x, pix_y) is inside the visible area
- p_tick  output  1  one-clk pixel strobe, once every CLK_DIV clks
- refr_tick  output  1  one-clk pulse per frame at the start of vertical blank
- pix_x  output  10  current horizontal count, 0..H_TOTAL-1
- pix_y  output  10  current vertical count, 0..V_TOTAL-1

## Operation

- Derived totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (default 800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (default 525). Both totals must be ≤1024. The counters are 10-bit unsigned.
- Divider counter div:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - p_tick = (div == CLK_DIV-1), combinational.
  - With CLK_DIV=1, p_tick is constantly high after reset.
- Horizontal counter h (drives pix_x):
  - Advances only on clk edges where p_tick=1.
  - At H_TOTAL-1 it wraps to 0; otherwise it increments.
- Vertical counter v (drives pix_y):
  - Advances only on the edge where h wraps.
  - At V_TOTAL-1 it wraps to 0; otherwise it increments.
- hsync is 0 iff h is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], which is [656, 751] by default.
- vsync is 0 iff v is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], which is [490, 491] by default.
- hsync and vsync are registers computed from the next-state counter values, so they change on the same edge as pix_x and pix_y (zero skew relative to the coordinates).
- video_on = (pix_x < H_DISPLAY) && (pix_y < V_DISPLAY), combinational.
- refr_tick = p_tick && (pix_x == 0) && (pix_y == V_DISPLAY), combinational. It is exactly one clk wide and occurs once per frame.
- Reset values (asynchronous):
  - div=0, pix_x=0, pix_y=0, hsync=1, vsync=1.
  - Hence p_tick=0 (for CLK_DIV>1), refr_tick=0, video_on=1.
- Reset asserted mid-frame forces all of the above values immediately, with no wait for a clock. Counting resumes from (0,0) on the first edge after deassertion.

## Timing

- After reset release, edge 1 moves div 0→1, and p_tick goes high (CLK_DIV=2). Edge 2 moves pix_x 0→1 and div back to 0.
- Each pixel coordinate is held for exactly CLK_DIV clks.
- One line is H_TOTAL×CLK_DIV clks (1600 by default). One frame is H_TOTAL×V_TOTAL×CLK_DIV clks (840000 by default).
- Line wrap: on the edge that moves pix_x 799→0, pix_y increments on that same edge.
- Frame wrap: (799,524)→(0,0) happens on a single edge.
- The hsync low pulse lasts H_SYNC×CLK_DIV clks (192). The vsync low pulse lasts V_SYNC×H_TOTAL×CLK_DIV clks (3200).
- There is no handshake; downstream blocks sample coordinates on any clk and qualify updates with p_tick or refr_tick.

## Test plan

- Reset release, default parameters:
  - p_tick high on the 1st clk after release.
  - pix_x=1 after the 2nd edge.
  - hsync=vsync=1 and video_on=1 at (0,0).
- Horizontal sweep:
  - pix_x steps 0..799 with each value held 2 clks.
  - hsync falls on the edge entering pix_x=656, stays low exactly 192 clks, and rises entering pix_x=752.
  - On the edge where pix_x goes 799→0, pix_y goes 0→1.
- Full frame, 840000 clks:
  - pix_y reaches 524, then (799,524)→(0,0) on one edge.
  - vsync is low only while pix_y ∈ {490, 491}, for 3200 clks.
  - refr_tick fires exactly once, at (0,480) with p_tick=1.
- video_on accounting over one frame:
  - Count of p_tick cycles with video_on=1 equals 307200.
  - video_on=0 at (640,0), at (0,480), and at (799,524).
- Reset mid-line:
  - Assert reset at pix_x=300, pix_y=100 while hsync=1, partway through a clk cycle.
  - Outputs go immediately to (0,0), hsync=vsync=1, p_tick=0.
  - After release, the first-pixel sequence matches the reset-release scenario.
- CLK_DIV=1 variant:
  - p_tick is constantly 1 after reset.
  - One line is 800 clks and one frame is 420000 clks.
  - refr_tick is still exactly one clk per frame.
